// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle RV32I control sequencer.
package core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [1:0]  HALT_EBREAK      = 2'd0;
    localparam logic [1:0]  HALT_ILLEGAL     = 2'd1;
    localparam logic [1:0]  HALT_TIMEOUT     = 2'd2;
    localparam logic [31:0] INST_EBREAK      = 32'h0010_0073;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/mc_core_ctrl_if.sv
// Instruction-fetch bus between the control sequencer and instruction memory.
// Handshake: imem_req/imem_addr are held stable until a cycle where imem_ready is
// also high; that cycle transfers imem_rdata and the request may then drop.
interface mc_core_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/mc_core_ctrl_fetch_timer.sv
// Counts unanswered fetch cycles; expired flags the last allowed wait cycle.
module fetch_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == W'(TIMEOUT - 1));
endmodule

// File: rtl/mc_core_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer: owns PC and IR, halts on ebreak,
// illegal instruction or fetch timeout, and keeps cycle/retire counters.
module mc_core_ctrl
    import core_pkg::*;
#(
    parameter logic [31:0] PC_RESET      = PC_RESET_DEFAULT,
    parameter int          FETCH_TIMEOUT = 16,
    parameter int          CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    mc_core_ctrl_if.master   bus,
    output logic [31:0]      inst,
    input  logic             dec_wen,
    input  logic             dec_illegal,
    output logic             rf_wen,
    output logic             alu_en,
    output logic [31:0]      pc,
    output logic             halt,
    output logic [1:0]       halt_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
    output state_t           dbg_state
);
    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      inst_q, inst_d;
    logic             halt_q, halt_d;
    logic [1:0]       halt_code_q, halt_code_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             imem_req_q, imem_req_d;
    logic             rf_wen_q, rf_wen_d;
    logic             alu_en_q, alu_en_d;
    logic             tmr_clr, tmr_en, tmr_expired;

    fetch_timer #(.TIMEOUT(FETCH_TIMEOUT)) u_fetch_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        halt_d      = halt_q;
        halt_code_d = halt_code_q;
        instret_d   = instret_q;
        cycle_d     = cycle_q;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;

        if (state_q != ST_HALT) begin
            cycle_d = cycle_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.imem_ready) begin
                    inst_d  = bus.imem_rdata;
                    tmr_clr = 1'b1;
                    state_d = ST_DECODE;
                end else if (tmr_expired) begin
                    tmr_clr     = 1'b1;
                    halt_d      = 1'b1;
                    halt_code_d = HALT_TIMEOUT;
                    state_d     = ST_HALT;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            // ebreak outranks the decoder's illegal flag.
            ST_DECODE: begin
                if (inst_q == INST_EBREAK) begin
                    halt_d      = 1'b1;
                    halt_code_d = HALT_EBREAK;
                    state_d     = ST_HALT;
                end else if (dec_illegal) begin
                    halt_d      = 1'b1;
                    halt_code_d = HALT_ILLEGAL;
                    state_d     = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB: begin
                pc_d      = pc_q + 32'd4;
                instret_d = instret_q + CNT_W'(1);
                state_d   = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase

        // Strobes are registered from the next state so they line up with it.
        imem_req_d = (state_d == ST_FETCH);
        alu_en_d   = (state_d == ST_EXEC);
        rf_wen_d   = (state_d == ST_WB) && dec_wen;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= PC_RESET;
            inst_q      <= '0;
            halt_q      <= 1'b0;
            halt_code_q <= HALT_EBREAK;
            cycle_q     <= '0;
            instret_q   <= '0;
            imem_req_q  <= 1'b0;
            rf_wen_q    <= 1'b0;
            alu_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            halt_q      <= halt_d;
            halt_code_q <= halt_code_d;
            cycle_q     <= cycle_d;
            instret_q   <= instret_d;
            imem_req_q  <= imem_req_d;
            rf_wen_q    <= rf_wen_d;
            alu_en_q    <= alu_en_d;
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc_q;
    assign inst          = inst_q;
    assign rf_wen        = rf_wen_q;
    assign alu_en        = alu_en_q;
    assign pc            = pc_q;
    assign halt          = halt_q;
    assign halt_code     = halt_code_q;
    assign cycle_cnt     = cycle_q;
    assign instret_cnt   = instret_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_mc_core_ctrl.sv
// Randomized program-level bench for mc_core_ctrl with a fetch/writeback scoreboard.
module tb_mc_core_ctrl;
    import core_pkg::*;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int TERM_EBREAK  = 0;
    localparam int TERM_ILLEGAL = 1;
    localparam int TERM_TIMEOUT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst, pc;
    logic        dec_wen = 1'b0, dec_illegal = 1'b0;
    logic        rf_wen, alu_en, halt;
    logic [1:0]  halt_code;
    logic [31:0] cycle_cnt, instret_cnt;
    state_t      dbg_state;

    mc_core_ctrl_if bus();

    mc_core_ctrl #(.PC_RESET(BASE), .FETCH_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .inst(inst), .dec_wen(dec_wen),
        .dec_illegal(dec_illegal), .rf_wen(rf_wen), .alu_en(alu_en), .pc(pc),
        .halt(halt), .halt_code(halt_code), .cycle_cnt(cycle_cnt),
        .instret_cnt(instret_cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Program image served by the memory driver.
    logic [31:0] p_word[0:15];
    int          p_wait[0:15];
    bit          p_wen[0:15];
    bit          p_ill[0:15];
    int          p_len = 0;
    int          fi = 0, wc = 0;

    // Scoreboard queues and end-of-program expectations.
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_wb_q[$];
    logic [31:0] exp_pc, exp_instret, exp_cycles, exp_inst, exp_req_cycles;
    logic [1:0]  exp_code;
    int          req_cycles = 0;
    int          n_vec = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory driver: answers the current fetch after its programmed wait.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.imem_ready = 1'b0;
        end else if (bus.imem_req) begin
            if (fi < p_len && wc == p_wait[fi]) begin
                bus.imem_ready = 1'b1;
                bus.imem_rdata = p_word[fi];
                dec_wen        = p_wen[fi];
                dec_illegal    = p_ill[fi];
                fi++;
                wc = 0;
            end else begin
                bus.imem_ready = 1'b0;
                bus.imem_rdata = $urandom();
                wc++;
            end
        end else begin
            bus.imem_ready = 1'b0;
        end
    end

    // Monitor: pops expectations whenever the DUT transfers a fetch or writes back.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (bus.imem_req) req_cycles++;
            if (bus.imem_req && bus.imem_ready) begin
                if (exp_addr_q.size() == 0) chk("fetch_unexpected", bus.imem_addr, 32'hxxxx_xxxx);
                else chk("fetch_addr", bus.imem_addr, exp_addr_q.pop_front());
            end
            if (rf_wen) begin
                if (exp_wb_q.size() == 0) chk("wb_unexpected", pc, 32'hxxxx_xxxx);
                else chk("wb_pc", pc, exp_wb_q.pop_front());
            end
            chk("strobe_excl", {31'b0, rf_wen && alu_en}, 32'd0);
            if (halt) chk("halt_quiet", {29'b0, bus.imem_req, rf_wen, alu_en}, 32'd0);
        end
    end

    task automatic gen_prog(input int n, input int term);
        logic [31:0] w;
        for (int i = 0; i <= n; i++) begin
            w = $urandom();
            if (w == INST_EBREAK) w = w ^ 32'h1;
            p_word[i] = w;
            p_wait[i] = ($urandom_range(0, 5) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 3);
            p_wen[i]  = 1'($urandom_range(0, 1));
            p_ill[i]  = 1'b0;
        end
        if (term == TERM_EBREAK) begin
            p_word[n] = INST_EBREAK;
            p_ill[n]  = 1'($urandom_range(0, 1));
        end else if (term == TERM_ILLEGAL) begin
            p_ill[n] = 1'b1;
        end
        p_len = (term == TERM_TIMEOUT) ? n : n + 1;
    endtask

    // Reference: each retired instruction costs wait+4 cycles, a halting one wait+2.
    task automatic build_exp(input int n, input int term);
        exp_addr_q.delete();
        exp_wb_q.delete();
        exp_cycles = 32'd1;
        exp_req_cycles = 32'd0;
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(BASE + 32'(4 * i));
            if (p_wen[i]) exp_wb_q.push_back(BASE + 32'(4 * i));
            exp_cycles += 32'(p_wait[i] + 4);
            exp_req_cycles += 32'(p_wait[i] + 1);
        end
        if (term == TERM_TIMEOUT) begin
            exp_cycles += 32'd16;
            exp_req_cycles += 32'd16;
            exp_code = 2'd2;
            exp_inst = (n > 0) ? p_word[n-1] : 32'd0;
        end else begin
            exp_addr_q.push_back(BASE + 32'(4 * n));
            exp_cycles += 32'(p_wait[n] + 2);
            exp_req_cycles += 32'(p_wait[n] + 1);
            exp_code = (term == TERM_EBREAK) ? 2'd0 : 2'd1;
            exp_inst = p_word[n];
        end
        exp_pc = BASE + 32'(4 * n);
        exp_instret = 32'(n);
    endtask

    task automatic do_reset(input int cyc);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (cyc) @(posedge clk);
        @(negedge clk);
        #2;
        chk("rst_pc", pc, BASE);
        chk("rst_inst", inst, 32'd0);
        chk("rst_halt", {30'b0, halt_code}, {31'b0, halt});
        chk("rst_halt_flag", {31'b0, halt}, 32'd0);
        chk("rst_cycle", cycle_cnt, 32'd0);
        chk("rst_instret", instret_cnt, 32'd0);
        chk("rst_strobes", {29'b0, bus.imem_req, rf_wen, alu_en}, 32'd0);
        chk("rst_state", {29'b0, dbg_state}, {29'b0, ST_IDLE});
        exp_addr_q.delete();
        exp_wb_q.delete();
        fi = 0;
        wc = 0;
        p_len = 0;
        req_cycles = 0;
        dec_wen = 1'b0;
        dec_illegal = 1'b0;
    endtask

    task automatic run_to_halt();
        bit got = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            #2;
            if (halt) begin
                got = 1'b1;
                break;
            end
        end
        chk("halt_seen", {31'b0, got}, 32'd1);
        repeat (2) @(negedge clk);
        #2;
        chk("halt_code", {30'b0, halt_code}, {30'b0, exp_code});
        chk("halt_pc", pc, exp_pc);
        chk("halt_instret", instret_cnt, exp_instret);
        chk("halt_cycles", cycle_cnt, exp_cycles);
        chk("halt_inst", inst, exp_inst);
        chk("req_cycles", 32'(req_cycles), exp_req_cycles);
        chk("fetch_q_empty", 32'(exp_addr_q.size()), 32'd0);
        chk("wb_q_empty", 32'(exp_wb_q.size()), 32'd0);
    endtask

    task automatic start_prog(input int n, input int term);
        build_exp(n, term);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'd0;

        // Three writing instructions, zero-wait memory, then ebreak.
        do_reset(2);
        gen_prog(3, TERM_EBREAK);
        for (int i = 0; i < 4; i++) p_wait[i] = 0;
        for (int i = 0; i < 3; i++) p_wen[i] = 1'b1;
        start_prog(3, TERM_EBREAK);
        run_to_halt();

        // Second fetch stalled five cycles.
        do_reset(1);
        gen_prog(3, TERM_EBREAK);
        p_wait[0] = 0; p_wait[1] = 5; p_wait[2] = 0; p_wait[3] = 0;
        start_prog(3, TERM_EBREAK);
        run_to_halt();

        // Illegal second instruction.
        do_reset(1);
        gen_prog(1, TERM_ILLEGAL);
        start_prog(1, TERM_ILLEGAL);
        run_to_halt();

        // Memory never answers.
        do_reset(1);
        gen_prog(0, TERM_TIMEOUT);
        start_prog(0, TERM_TIMEOUT);
        run_to_halt();

        // One-cycle reset during the first EXEC.
        do_reset(1);
        gen_prog(3, TERM_EBREAK);
        start_prog(3, TERM_EBREAK);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #2;
            if (alu_en) break;
        end
        chk("exec_reached", {31'b0, alu_en}, 32'd1);
        do_reset(1);

        // One-cycle reset during a stalled fetch, then a normal program.
        gen_prog(2, TERM_EBREAK);
        p_wait[0] = 10;
        start_prog(2, TERM_EBREAK);
        for (int k = 0; k < 100 && req_cycles < 4; k++) begin
            @(negedge clk);
            #2;
        end
        chk("stall_reached", 32'(req_cycles), 32'd4);
        do_reset(1);
        gen_prog(2, TERM_EBREAK);
        start_prog(2, TERM_EBREAK);
        run_to_halt();

        for (int s = 0; s < 15; s++) begin
            int n;
            n = $urandom_range(1, 6);
            do_reset($urandom_range(1, 2));
            gen_prog(n, s % 3);
            start_prog(n, s % 3);
            run_to_halt();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mc_core_ctrl.md
Name: mc_core_ctrl

Overview:
Multi-cycle control sequencer for the single-issue RV32I core. It owns the PC and the instruction register (IR) and fetches over a req/ready handshake to instruction memory. It presents the IR to the decoder, then sequences DECODE/EXEC/WB so the register file is written exactly once per retired instruction. It halts on ebreak, on an illegal instruction, or on a fetch timeout, and keeps retire and cycle counters for the simulation harness.

Parameters:
PC_RESET, 32'h8000_0000, PC value loaded on reset.
FETCH_TIMEOUT, 16, max cycles imem_req may wait for imem_ready before halting; must be >= 1.
CNT_W, 32, width of cycle_cnt and instret_cnt.

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  synchronous, active-low reset
imem_req  out  1  fetch request, held until accepted
imem_addr  out  32  fetch address, equals pc while imem_req is high
imem_ready  in  1  memory accepts and returns data this cycle
imem_rdata  in  32  instruction word, valid when imem_req && imem_ready
inst  out  32  IR contents, drives decoder
dec_wen  in  1  decoder: instruction writes rd
dec_illegal  in  1  decoder: opcode/funct not supported
rf_wen  out  1  register-file write strobe, one-cycle pulse in WB
alu_en  out  1  high during EXEC; enables the ALU result register
pc  out  32  current PC
halt  out  1  sticky halt flag
halt_code  out  2  0=ebreak, 1=illegal, 2=fetch timeout, 3=reserved
cycle_cnt  out  CNT_W  cycles since reset release, stops at halt
instret_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (rst_n low at an edge): state=IDLE, pc=PC_RESET, inst=0, halt=0, halt_code=0, counters=0, timeout counter=0, imem_req=rf_wen=alu_en=0. Reset takes effect mid-instruction and mid-handshake; an outstanding fetch is abandoned and its data dropped.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE -> FETCH unconditionally on the next edge.
- FETCH:
  - imem_req=1 and imem_addr=pc, both stable until accepted.
  - On an edge with imem_ready=1: inst<=imem_rdata, timeout counter cleared, -> DECODE.
  - Otherwise the timeout counter increments. When it reaches FETCH_TIMEOUT-1 without ready: -> HALT, halt_code=2.
  - Ready is sampled only in FETCH; ready in other states is ignored.
- DECODE (1 cycle): inst is stable, decoder outputs are sampled at the end of the cycle.
  - Priority: if inst==32'h0010_0073 (ebreak) -> HALT, code 0; else if dec_illegal -> HALT, code 1; else -> EXEC.
  - ebreak is not counted as retired.
- EXEC (1 cycle): alu_en=1 -> WB.
- WB (1 cycle):
  - rf_wen=dec_wen, a single-cycle pulse.
  - At the end of the cycle: pc<=pc+4 (mod 2^32, wraps silently), instret_cnt+=1 (wraps), -> FETCH.
- Latency: with zero-wait memory, 4 cycles per instruction (FETCH, DECODE, EXEC, WB). The first imem_req appears 1 cycle after reset release.
- HALT: absorbing until reset.
  - halt=1; all strobes low; pc, inst and counters frozen.
  - halt and halt_code are set on the same edge that enters HALT.
- cycle_cnt increments every cycle in all states except HALT, IDLE included; wraps at 2^CNT_W.
- rf_wen and alu_en are never high in the same cycle. rf_wen is never high outside WB.

Decomposition:
- Shared package core_pkg:
  - state enum (3-bit encoding);
  - halt_code constants (HALT_EBREAK=0, HALT_ILLEGAL=1, HALT_TIMEOUT=2);
  - INST_EBREAK=32'h0010_0073;
  - PC_RESET default.
- One natural sub-module, fetch_timer: the timeout counter with clear/enable/expired. Everything else stays in mc_core_ctrl.

Test Plan:
- Reset release, imem_ready tied 1, stream of addi (dec_wen=1) -> imem_req at cycle 1, imem_addr 0x8000_0000, 0x8000_0004, 0x8000_0008 every 4 cycles; rf_wen pulses once per instruction; instret_cnt=3 after 12 cycles.
- imem_ready delayed 5 cycles on the second fetch -> imem_req and imem_addr=0x8000_0004 held all 5 cycles; no rf_wen; retire 5 cycles later than the zero-wait case.
- dec_illegal=1 on the 2nd instruction -> HALT after that DECODE; halt=1, halt_code=1, pc=0x8000_0004, instret_cnt=1; no further imem_req or rf_wen.
- Fetch word 0x0010_0073 -> halt_code=0, instret_cnt unchanged, cycle_cnt frozen from the next cycle.
- imem_ready held 0, FETCH_TIMEOUT=16 -> halt, halt_code=2, exactly 16 cycles of imem_req high.
- rst_n low for 1 cycle during EXEC, and separately during a stalled FETCH -> next cycle IDLE, pc=0x8000_0000, counters 0, no rf_wen; normal fetch resumes.
